// File: rtl/video_channel_mixer_pkg.sv
// video_pkg: mode encodings and helpers shared by the channel mixer, its
// interface and the testbench.
//   MODE_W / NUM_MODES : width and count of the channel permutation modes
//   mode_t             : mode value type
//   mode_inc/mode_dec  : step a mode forward/backward, wrapping inside 0..5
package video_pkg;

  localparam int MODE_W    = 3;
  localparam int NUM_MODES = 6;

  typedef logic [MODE_W-1:0] mode_t;

  // Output (R,G,B) taken from input channels:
  localparam mode_t MODE_ID      = 3'd0;  // R,G,B
  localparam mode_t MODE_SWAP_RG = 3'd1;  // G,R,B
  localparam mode_t MODE_SWAP_RB = 3'd2;  // B,G,R
  localparam mode_t MODE_SWAP_GB = 3'd3;  // R,B,G
  localparam mode_t MODE_ROT_L   = 3'd4;  // G,B,R
  localparam mode_t MODE_ROT_R   = 3'd5;  // B,R,G

  function automatic mode_t mode_inc(input mode_t m);
    return (m >= mode_t'(NUM_MODES - 1)) ? MODE_ID : m + mode_t'(1);
  endfunction

  function automatic mode_t mode_dec(input mode_t m);
    return (m == MODE_ID) ? mode_t'(NUM_MODES - 1) : m - mode_t'(1);
  endfunction

endpackage

// File: rtl/video_channel_mixer_if.sv
// Pixel stream bundle for video_channel_mixer.
//   iMask/iVALID/iSOF/iRed/iGreen/iBlue : incoming pixel and qualifiers
//   oRed/oGreen/oBlue/oVALID            : permuted + masked pixel out
//   oMode                               : currently active mode
// master = pixel source / sink side, slave = the mixer.
interface video_channel_mixer_if #(
  parameter int DATA_W = 10
);
  import video_pkg::*;

  logic [2:0]        iMask;
  logic              iVALID;
  logic              iSOF;
  logic [DATA_W-1:0] iRed;
  logic [DATA_W-1:0] iGreen;
  logic [DATA_W-1:0] iBlue;
  logic [DATA_W-1:0] oRed;
  logic [DATA_W-1:0] oGreen;
  logic [DATA_W-1:0] oBlue;
  logic              oVALID;
  mode_t             oMode;

  modport master (
    output iMask, iVALID, iSOF, iRed, iGreen, iBlue,
    input  oRed, oGreen, oBlue, oVALID, oMode
  );

  modport slave (
    input  iMask, iVALID, iSOF, iRed, iGreen, iBlue,
    output oRed, oGreen, oBlue, oVALID, oMode
  );

endinterface

// File: rtl/video_channel_mixer_key_debounce.sv
// key_debounce: 2-flop synchroniser, stability counter and press detect for
// one active-low push-button.
//   iCLK, iRST : clock, synchronous active-high reset
//   iKey       : raw key level (pressed = 0), asynchronous
//   oLevel     : debounced level (1 = released)
//   oPress     : one-cycle pulse when the debounced level falls 1 -> 0
module key_debounce #(
  parameter int DEB_CYC = 50000,
  parameter int DEB_W   = 16
) (
  input  logic iCLK,
  input  logic iRST,
  input  logic iKey,
  output logic oLevel,
  output logic oPress
);

  logic             sync_a;
  logic             sync_b;
  logic             level;
  logic [DEB_W-1:0] cnt;

  // cnt counts consecutive cycles the synchronised key disagrees with the
  // accepted level; any agreement (a bounce back) clears it.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      sync_a <= 1'b1;
      sync_b <= 1'b1;
      level  <= 1'b1;
      cnt    <= '0;
      oPress <= 1'b0;
    end else begin
      sync_a <= iKey;
      sync_b <= sync_a;
      oPress <= 1'b0;
      if (sync_b == level) begin
        cnt <= '0;
      end else if (cnt == DEB_W'(DEB_CYC - 1)) begin
        cnt    <= '0;
        level  <= sync_b;
        // level is still the old value here: 1 means this is a press
        oPress <= level;
      end else begin
        cnt <= cnt + DEB_W'(1);
      end
    end
  end

  assign oLevel = level;

endmodule

// File: rtl/video_channel_mixer.sv
// video_channel_mixer: two-stage RGB channel permuter with per-channel
// zero mask. Two keys step a pending mode; it becomes active only on a
// valid start-of-frame pixel so a frame is never torn.
//   iCLK, iRST : pixel clock, synchronous active-high reset
//   iButton    : raw keys, active-low; [1] = next mode, [2] = previous mode
//   bus        : pixel stream in/out, active mode (slave modport)
module video_channel_mixer
  import video_pkg::*;
#(
  parameter int DATA_W  = 10,
  parameter int DEB_CYC = 50000,
  parameter int DEB_W   = 16
) (
  input  logic                 iCLK,
  input  logic                 iRST,
  input  logic [2:1]           iButton,
  video_channel_mixer_if.slave bus
);

  logic [2:1]        key_press;
  logic [2:1]        key_level_unused;

  mode_t             pending_mode;
  mode_t             active_mode;
  mode_t             eff_mode;
  logic              sof_take;

  logic              s1_valid;
  logic [2:0]        s1_mask;
  mode_t             s1_mode;
  logic [DATA_W-1:0] s1_r;
  logic [DATA_W-1:0] s1_g;
  logic [DATA_W-1:0] s1_b;

  logic [DATA_W-1:0] perm_r;
  logic [DATA_W-1:0] perm_g;
  logic [DATA_W-1:0] perm_b;

  logic              s2_valid;
  logic [DATA_W-1:0] s2_r;
  logic [DATA_W-1:0] s2_g;
  logic [DATA_W-1:0] s2_b;

  key_debounce #(.DEB_CYC(DEB_CYC), .DEB_W(DEB_W)) u_key_next (
    .iCLK   (iCLK),
    .iRST   (iRST),
    .iKey   (iButton[1]),
    .oLevel (key_level_unused[1]),
    .oPress (key_press[1])
  );

  key_debounce #(.DEB_CYC(DEB_CYC), .DEB_W(DEB_W)) u_key_prev (
    .iCLK   (iCLK),
    .iRST   (iRST),
    .iKey   (iButton[2]),
    .oLevel (key_level_unused[2]),
    .oPress (key_press[2])
  );

  // Simultaneous presses are treated as "back to identity".
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      pending_mode <= MODE_ID;
    end else if (key_press[1] && key_press[2]) begin
      pending_mode <= MODE_ID;
    end else if (key_press[1]) begin
      pending_mode <= mode_inc(pending_mode);
    end else if (key_press[2]) begin
      pending_mode <= mode_dec(pending_mode);
    end
  end

  // The SOF pixel itself already uses the newly loaded mode.
  assign sof_take = bus.iVALID && bus.iSOF;
  assign eff_mode = sof_take ? pending_mode : active_mode;

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      active_mode <= MODE_ID;
    end else if (sof_take) begin
      active_mode <= pending_mode;
    end
  end

  // Stage 1: capture pixel, mask and the mode it must be processed with.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      s1_valid <= 1'b0;
      s1_mask  <= '0;
      s1_mode  <= MODE_ID;
      s1_r     <= '0;
      s1_g     <= '0;
      s1_b     <= '0;
    end else begin
      s1_valid <= bus.iVALID;
      if (bus.iVALID) begin
        s1_mask <= bus.iMask;
        s1_mode <= eff_mode;
        s1_r    <= bus.iRed;
        s1_g    <= bus.iGreen;
        s1_b    <= bus.iBlue;
      end
    end
  end

  // Unreachable codes 6/7 fall into the identity default.
  always_comb begin
    perm_r = s1_r;
    perm_g = s1_g;
    perm_b = s1_b;
    case (s1_mode)
      MODE_SWAP_RG: begin perm_r = s1_g; perm_g = s1_r; perm_b = s1_b; end
      MODE_SWAP_RB: begin perm_r = s1_b; perm_g = s1_g; perm_b = s1_r; end
      MODE_SWAP_GB: begin perm_r = s1_r; perm_g = s1_b; perm_b = s1_g; end
      MODE_ROT_L:   begin perm_r = s1_g; perm_g = s1_b; perm_b = s1_r; end
      MODE_ROT_R:   begin perm_r = s1_b; perm_g = s1_r; perm_b = s1_g; end
      default:      begin perm_r = s1_r; perm_g = s1_g; perm_b = s1_b; end
    endcase
  end

  // Stage 2: mask acts on output channel positions, after the permutation.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      s2_valid <= 1'b0;
      s2_r     <= '0;
      s2_g     <= '0;
      s2_b     <= '0;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_r <= s1_mask[0] ? '0 : perm_r;
        s2_g <= s1_mask[1] ? '0 : perm_g;
        s2_b <= s1_mask[2] ? '0 : perm_b;
      end
    end
  end

  assign bus.oRed   = s2_r;
  assign bus.oGreen = s2_g;
  assign bus.oBlue  = s2_b;
  assign bus.oVALID = s2_valid;
  assign bus.oMode  = active_mode;

endmodule

// File: tb/tb_video_channel_mixer.sv
module tb_video_channel_mixer;
  import video_pkg::*;

  localparam int DW      = 10;
  localparam int DEB_CYC = 4;
  localparam int DEB_W   = 4;

  logic       clk    = 1'b0;
  logic       rst    = 1'b1;
  logic [2:1] button = 2'b11;

  video_channel_mixer_if #(.DATA_W(DW)) bus ();

  video_channel_mixer #(.DATA_W(DW), .DEB_CYC(DEB_CYC), .DEB_W(DEB_W)) dut (
    .iCLK    (clk),
    .iRST    (rst),
    .iButton (button),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic [3*DW-1:0] rgb;
    int              stamp;
  } exp_t;
  exp_t sbq[$];

  typedef struct {
    logic          v;
    logic          sof;
    logic [2:0]    mask;
    logic [DW-1:0] r, g, b;
    logic [DW-1:0] er, eg, eb;
  } vec_t;
  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference channel mapping written from the mode table.
  function automatic logic [3*DW-1:0] model(input int m, input logic [2:0] mask,
                                             input logic [DW-1:0] r, g, b);
    logic [DW-1:0] o_r, o_g, o_b;
    o_r = r; o_g = g; o_b = b;
    case (m)
      1: begin o_r = g; o_g = r; o_b = b; end
      2: begin o_r = b; o_g = g; o_b = r; end
      3: begin o_r = r; o_g = b; o_b = g; end
      4: begin o_r = g; o_g = b; o_b = r; end
      5: begin o_r = b; o_g = r; o_b = g; end
      default: ;
    endcase
    if (mask[0]) o_r = '0;
    if (mask[1]) o_g = '0;
    if (mask[2]) o_b = '0;
    return {o_r, o_g, o_b};
  endfunction

  // Output monitor: every valid output must match the oldest expectation,
  // exactly two cycles after that pixel was driven.
  always @(negedge clk) begin
    exp_t e;
    if (bus.oVALID) begin
      if (sbq.size() == 0) begin
        n_total++;
        $display("FAIL spurious_valid: oVALID=1 with no pixel outstanding (cycle %0d)", cyc);
      end else begin
        e = sbq.pop_front();
        check("pix_data", 64'({bus.oRed, bus.oGreen, bus.oBlue}), 64'(e.rgb));
        check("pix_latency", 64'(cyc), 64'(e.stamp + 2));
      end
    end
  end

  task automatic step(input logic v, input logic sof, input logic [2:0] mask,
                      input logic [DW-1:0] r, g, b, input logic [3*DW-1:0] e);
    @(posedge clk);
    #1;
    bus.iVALID = v;
    bus.iSOF   = sof;
    bus.iMask  = mask;
    bus.iRed   = r;
    bus.iGreen = g;
    bus.iBlue  = b;
    if (v && !rst) sbq.push_back('{e, cyc});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 3'b000, '0, '0, '0, '0);
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    idle(1);
    while (sbq.size() != 0 && k < 20) begin
      @(posedge clk);
      k++;
    end
    check(name, 64'(sbq.size()), 64'd0);
  endtask

  // keys: bit set = hold that key pressed, then release and let it settle.
  task automatic press(input logic [2:1] keys);
    button = ~keys;
    idle(DEB_CYC + 6);
    button = 2'b11;
    idle(DEB_CYC + 6);
  endtask

  task automatic frame(input int m, input string name);
    step(1'b1, 1'b1, 3'b000, 10'd1, 10'd2, 10'd3, model(m, 3'b000, 10'd1, 10'd2, 10'd3));
    step(1'b1, 1'b0, 3'b000, 10'h3FF, 10'h155, 10'h0AA,
         model(m, 3'b000, 10'h3FF, 10'h155, 10'h0AA));
    drain({name, "_drain"});
    check({name, "_mode"}, 64'(bus.oMode), 64'(m));
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    vecs[0] = '{1'b1, 1'b1, 3'b000, 10'h3FF, 10'h155, 10'h0AA, 10'h3FF, 10'h155, 10'h0AA};
    vecs[1] = '{1'b1, 1'b0, 3'b000, 10'h155, 10'h0AA, 10'h3FF, 10'h155, 10'h0AA, 10'h3FF};
    vecs[2] = '{1'b0, 1'b0, 3'b000, 10'h111, 10'h222, 10'h333, 10'h000, 10'h000, 10'h000};
    vecs[3] = '{1'b1, 1'b0, 3'b010, 10'h3FF, 10'h3FF, 10'h3FF, 10'h3FF, 10'h000, 10'h3FF};
    vecs[4] = '{1'b1, 1'b0, 3'b111, 10'd1,   10'd2,   10'd3,   10'd0,   10'd0,   10'd0};
    vecs[5] = '{1'b1, 1'b0, 3'b001, 10'h012, 10'h034, 10'h056, 10'h000, 10'h034, 10'h056};

    bus.iVALID = 1'b0; bus.iSOF = 1'b0; bus.iMask = '0;
    bus.iRed = '0; bus.iGreen = '0; bus.iBlue = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #5;
    check("reset_valid", 64'(bus.oVALID), 64'd0);
    check("reset_data", 64'({bus.oRed, bus.oGreen, bus.oBlue}), 64'd0);
    check("reset_mode", 64'(bus.oMode), 64'd0);

    // Identity stream with masks, including a bubble.
    for (int i = 0; i < 6; i++)
      step(vecs[i].v, vecs[i].sof, vecs[i].mask, vecs[i].r, vecs[i].g, vecs[i].b,
           {vecs[i].er, vecs[i].eg, vecs[i].eb});
    drain("table_drain");

    // Clean press on next key: pixels before SOF stay identity.
    press(2'b01);
    step(1'b1, 1'b0, 3'b000, 10'd1, 10'd2, 10'd3, {10'd1, 10'd2, 10'd3});
    step(1'b1, 1'b1, 3'b000, 10'd1, 10'd2, 10'd3, {10'd2, 10'd1, 10'd3});
    drain("mode1_drain");
    check("mode1_mode", 64'(bus.oMode), 64'd1);

    // Bouncy press: exactly one increment (1 -> 2).
    for (int i = 0; i < 10; i++) begin
      button[1] = ((i / 2) % 2 == 1);
      idle(1);
    end
    button[1] = 1'b0;
    idle(10);
    button[1] = 1'b1;
    idle(10);
    frame(2, "bounce");

    // Up to mode 4, then mask 101 on output positions.
    press(2'b01);
    press(2'b01);
    frame(4, "mode4");
    step(1'b1, 1'b0, 3'b101, 10'd1, 10'd2, 10'd3, {10'd0, 10'd3, 10'd0});
    drain("mask_drain");

    // Both keys together from 4 -> 0.
    press(2'b11);
    frame(0, "both");

    // Prev key wraps 0 -> 5; next key wraps 5 -> 0.
    press(2'b10);
    step(1'b1, 1'b1, 3'b000, 10'd1, 10'd2, 10'd3, {10'd3, 10'd1, 10'd2});
    drain("mode5_drain");
    press(2'b01);
    frame(0, "wrap");

    // Reach mode 3, then reset in the middle of a frame.
    press(2'b10);
    press(2'b10);
    press(2'b10);
    step(1'b1, 1'b1, 3'b000, 10'd1, 10'd2, 10'd3, {10'd1, 10'd3, 10'd2});
    for (int i = 0; i < 3; i++)
      step(1'b1, 1'b0, 3'b000, 10'd4, 10'd5, 10'd6, {10'd4, 10'd6, 10'd5});
    @(posedge clk);
    #1 rst = 1'b1;
    #5 sbq.delete();
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.iVALID = 1'b1; bus.iSOF = 1'b0; bus.iMask = '0;
    bus.iRed = 10'd7; bus.iGreen = 10'd8; bus.iBlue = 10'd9;
    sbq.push_back('{{10'd7, 10'd8, 10'd9}, cyc});
    #5;
    check("rst_flush0", 64'(bus.oVALID), 64'd0);
    check("rst_mode", 64'(bus.oMode), 64'd0);
    step(1'b1, 1'b0, 3'b000, 10'd1, 10'd2, 10'd3, {10'd1, 10'd2, 10'd3});
    #5;
    check("rst_flush1", 64'(bus.oVALID), 64'd0);

    // Pending changes mid-frame must not affect the rest of the frame.
    button = 2'b10;
    for (int i = 0; i < DEB_CYC + 6; i++)
      step(1'b1, 1'b0, 3'b000, 10'd1, 10'd2, 10'd3, {10'd1, 10'd2, 10'd3});
    button = 2'b11;
    for (int i = 0; i < DEB_CYC + 6; i++)
      step(1'b1, 1'b0, 3'b000, 10'd3, 10'd2, 10'd1, {10'd3, 10'd2, 10'd1});
    drain("post_rst_drain");
    check("post_rst_mode", 64'(bus.oMode), 64'd0);
    frame(1, "post_rst_sof");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
